// File: rtl/ad9361_pkg.sv
// Shared types, defaults and the width helper for the AD9361 receive burst controller.
package ad9361_pkg;

    localparam int LEN_WIDTH_DEF = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ENA_ON,
        ST_SETTLE,
        ST_CAPTURE,
        ST_ENA_OFF,
        ST_GUARD
    } state_e;

    // Bits needed to hold values 0..value-1.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/ad9361_rx_burst_ctrl_if.sv
// Request handshake and sample stream between the burst controller and its neighbours.
interface ad9361_rx_burst_ctrl_if #(
    parameter int LEN_WIDTH = 16
);
    logic                 req_valid;
    logic                 req_ready;
    logic [LEN_WIDTH-1:0] req_len;
    logic                 in_valid;
    logic                 out_valid;
    logic                 out_last;

    modport master (
        output req_valid, req_len, in_valid,
        input  req_ready, out_valid, out_last
    );

    modport slave (
        input  req_valid, req_len, in_valid,
        output req_ready, out_valid, out_last
    );
endinterface

// File: rtl/ad9361_cycle_timer.sv
// Loadable down-counter; expire pulses on the last cycle of a loaded interval.
module ad9361_cycle_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] load,
    output logic             expire
);
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (start) begin
            cnt_d = load;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A load of N yields N cycles with the count at N..1; expire marks the last.
    assign expire = (cnt_q == WIDTH'(1));
endmodule

// File: rtl/ad9361_rx_burst_ctrl.sv
// AD9361 pulse-mode ENSM receive burst sequencer with gated sample strobe.
// Build option: define AD9361_RX_ABORT_EN to make the abort input effective.
//   state      | meaning
//   ST_IDLE    | ready for a request
//   ST_ENA_ON  | entry ENABLE pulse
//   ST_SETTLE  | wait for the receive path to settle, samples ignored
//   ST_CAPTURE | pass samples until the counter runs out
//   ST_ENA_OFF | exit ENABLE pulse
//   ST_GUARD   | hold-off before the next request, done on the last cycle
module ad9361_rx_burst_ctrl
    import ad9361_pkg::*;
#(
    parameter int ENABLE_CYCLES = 4,
    parameter int SETTLE_CYCLES = 16,
    parameter int GUARD_CYCLES  = 8,
    parameter int LEN_WIDTH     = LEN_WIDTH_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   abort,
    output logic                   enable,
    output logic                   txnrx,
    output logic                   busy,
    output logic                   done,
    output logic                   aborted,
    ad9361_rx_burst_ctrl_if.slave  bus
);
    localparam int MAX_AB  = (ENABLE_CYCLES > SETTLE_CYCLES) ? ENABLE_CYCLES : SETTLE_CYCLES;
    localparam int TMR_MAX = (MAX_AB > GUARD_CYCLES) ? MAX_AB : GUARD_CYCLES;
    localparam int TMR_W   = clog2(TMR_MAX + 1);

`ifdef AD9361_RX_ABORT_EN
    localparam bit ABORT_ON = 1'b1;
`else
    localparam bit ABORT_ON = 1'b0;
`endif

    state_e               state_q, state_d;
    logic [LEN_WIDTH-1:0] rem_q, rem_d;
    logic                 aborted_q, aborted_d;
    logic                 zdone_q, zdone_d;
    logic                 tmr_start;
    logic [TMR_W-1:0]     tmr_load;
    logic                 tmr_expire;
    logic                 abort_eff;
    logic                 last_smp;

    assign abort_eff = abort & ABORT_ON;
    assign last_smp  = bus.in_valid && (rem_q == LEN_WIDTH'(1));
    assign txnrx     = 1'b0;

    ad9361_cycle_timer #(.WIDTH(TMR_W)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .start  (tmr_start),
        .load   (tmr_load),
        .expire (tmr_expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            rem_q     <= '0;
            aborted_q <= 1'b0;
            zdone_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            aborted_q <= aborted_d;
            zdone_q   <= zdone_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        aborted_d = aborted_q;
        zdone_d   = 1'b0;
        tmr_start = 1'b0;
        tmr_load  = TMR_W'(ENABLE_CYCLES);
        unique case (state_q)
            ST_IDLE: begin
                aborted_d = 1'b0;
                if (bus.req_valid) begin
                    if (bus.req_len == '0) begin
                        zdone_d = 1'b1;
                    end else begin
                        rem_d     = bus.req_len;
                        state_d   = ST_ENA_ON;
                        tmr_start = 1'b1;
                    end
                end
            end
            ST_ENA_ON: begin
                // An abort here is remembered so the entry pulse still completes.
                if (abort_eff) aborted_d = 1'b1;
                if (tmr_expire) begin
                    tmr_start = 1'b1;
                    if (aborted_q || abort_eff) begin
                        state_d = ST_ENA_OFF;
                    end else begin
                        state_d  = ST_SETTLE;
                        tmr_load = TMR_W'(SETTLE_CYCLES);
                    end
                end
            end
            ST_SETTLE: begin
                if (abort_eff) begin
                    aborted_d = 1'b1;
                    state_d   = ST_ENA_OFF;
                    tmr_start = 1'b1;
                end else if (tmr_expire) begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (bus.in_valid) rem_d = rem_q - LEN_WIDTH'(1);
                // The final sample wins over a coincident abort.
                if (last_smp) begin
                    state_d   = ST_ENA_OFF;
                    tmr_start = 1'b1;
                end else if (abort_eff) begin
                    aborted_d = 1'b1;
                    state_d   = ST_ENA_OFF;
                    tmr_start = 1'b1;
                end
            end
            ST_ENA_OFF: begin
                if (tmr_expire) begin
                    state_d   = ST_GUARD;
                    tmr_start = 1'b1;
                    tmr_load  = TMR_W'(GUARD_CYCLES);
                end
            end
            ST_GUARD: begin
                if (tmr_expire) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        enable        = 1'b0;
        busy          = 1'b1;
        bus.req_ready = 1'b0;
        bus.out_valid = 1'b0;
        bus.out_last  = 1'b0;
        done          = zdone_q;
        aborted       = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                busy          = 1'b0;
                bus.req_ready = 1'b1;
            end
            ST_ENA_ON, ST_ENA_OFF: enable = 1'b1;
            ST_CAPTURE: begin
                bus.out_valid = bus.in_valid;
                bus.out_last  = last_smp;
            end
            ST_GUARD: begin
                done    = tmr_expire;
                aborted = tmr_expire & aborted_q;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_ad9361_rx_burst_ctrl.sv
// Scoreboard bench for ad9361_rx_burst_ctrl: stimulus queues expected strobes, done events
// and ENABLE pulse widths; a negedge monitor pops and compares them.
module tb_ad9361_rx_burst_ctrl;

    typedef struct {
        bit is_done;
        bit flag;
        int cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic abort = 1'b0;
    logic enable, txnrx, busy, done, aborted;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t exp_q[$];
    int   en_q[$];
    int   en_run = 0;
    exp_t mon_e;

    ad9361_rx_burst_ctrl_if #(.LEN_WIDTH(16)) bus ();

    ad9361_rx_burst_ctrl dut (
        .clk     (clk),
        .rst     (rst),
        .abort   (abort),
        .enable  (enable),
        .txnrx   (txnrx),
        .busy    (busy),
        .done    (done),
        .aborted (aborted),
        .bus     (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void push_exp(input bit d, input bit f, input int c);
        exp_t e;
        e.is_done = d;
        e.flag    = f;
        e.cyc     = c;
        exp_q.push_back(e);
    endfunction

    // Monitor
    always @(negedge clk) begin
        if (rst) begin
            en_run = 0;
        end else begin
            if (bus.out_last) check("out_last_gated", bus.out_valid, 1);
            if (aborted) check("aborted_with_done", done, 1);
            if (bus.out_valid) begin
                check("out_valid_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    check("out_kind", 0, mon_e.is_done);
                    check("out_last", bus.out_last, mon_e.flag);
                    check("out_cycle", cyc, mon_e.cyc);
                end
            end
            if (done) begin
                check("done_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    check("done_kind", 1, mon_e.is_done);
                    check("done_aborted", aborted, mon_e.flag);
                    check("done_cycle", cyc, mon_e.cyc);
                end
            end
            if (enable) begin
                en_run++;
            end else if (en_run > 0) begin
                check("enable_pulse_expected", en_q.size() > 0, 1);
                if (en_q.size() > 0) check("enable_width", en_run, en_q.pop_front());
                en_run = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_to(input int t);
        while (cyc < t) tick();
    endtask

    task automatic handshake(input int len);
        bus.req_valid = 1'b1;
        bus.req_len   = 16'(len);
        tick();
        bus.req_valid = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int h;
        int h2;
        bus.req_valid = 1'b0;
        bus.req_len   = '0;
        bus.in_valid  = 1'b0;
        tick(); tick(); tick();
        rst = 1'b0;
        bus.in_valid = 1'b1;   // strobes while idle must not leak through
        tick();
        check("rst_req_ready", bus.req_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_enable", enable, 0);
        check("rst_done", done, 0);
        check("rst_aborted", aborted, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_txnrx", txnrx, 0);
        bus.in_valid = 1'b0;
        tick();

        // len=3, five strobes, only first three pass
        h = cyc;
        en_q.push_back(4); en_q.push_back(4);
        handshake(3);
        tick_to(h + 10);
        check("busy_in_burst", busy, 1);
        check("ready_in_burst", bus.req_ready, 0);
        for (int i = 0; i < 5; i++) begin
            tick_to(h + 21 + 2 * i);
            bus.in_valid = 1'b1;
            if (i < 3) push_exp(0, i == 2, h + 21 + 2 * i);
            if (i == 2) push_exp(1, 0, h + 37);
            tick();
            bus.in_valid = 1'b0;
        end
        tick_to(h + 39);

        // zero length request
        h = cyc;
        push_exp(1, 0, h + 1);
        handshake(0);
        check("zero_len_ready", bus.req_ready, 1);
        check("zero_len_busy", busy, 0);
        tick_to(h + 4);

        // in_valid held through entry and settle, len=2
        h = cyc;
        en_q.push_back(4); en_q.push_back(4);
        handshake(2);
        bus.in_valid = 1'b1;
        push_exp(0, 0, h + 21);
        push_exp(0, 1, h + 22);
        push_exp(1, 0, h + 34);
        tick_to(h + 25);
        bus.in_valid = 1'b0;
        tick_to(h + 36);

        // abort in capture after one of ten samples
        h = cyc;
        en_q.push_back(4); en_q.push_back(4);
        handshake(10);
        tick_to(h + 21);
        bus.in_valid = 1'b1;
        push_exp(0, 0, h + 21);
        tick();
        bus.in_valid = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
`ifdef AD9361_RX_ABORT_EN
        push_exp(1, 1, h + 34);
        tick_to(h + 36);
`else
        for (int i = 0; i < 9; i++) begin
            tick_to(h + 23 + i);
            bus.in_valid = 1'b1;
            push_exp(0, i == 8, h + 23 + i);
            if (i == 8) push_exp(1, 0, h + 23 + i + 12);
            tick();
            bus.in_valid = 1'b0;
        end
        tick_to(h + 45);
`endif

        // abort coincident with the final strobe completes normally
        h = cyc;
        en_q.push_back(4); en_q.push_back(4);
        handshake(1);
        tick_to(h + 21);
        bus.in_valid = 1'b1;
        abort = 1'b1;
        push_exp(0, 1, h + 21);
        push_exp(1, 0, h + 33);
        tick();
        bus.in_valid = 1'b0;
        abort = 1'b0;
        tick_to(h + 35);

        // reset during capture, then a normal len=1 burst
        h = cyc;
        en_q.push_back(4);
        handshake(4);
        tick_to(h + 21);
        bus.in_valid = 1'b1;
        push_exp(0, 0, h + 21);
        tick();
        bus.in_valid = 1'b0;
        tick_to(h + 23);
        rst = 1'b1;
        tick();
        check("midrst_enable", enable, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        rst = 1'b0;
        tick();
        check("midrst_ready", bus.req_ready, 1);
        tick_to(h + 30);
        h2 = cyc;
        en_q.push_back(4); en_q.push_back(4);
        handshake(1);
        tick_to(h2 + 21);
        bus.in_valid = 1'b1;
        push_exp(0, 1, h2 + 21);
        push_exp(1, 0, h2 + 33);
        tick();
        bus.in_valid = 1'b0;
        tick_to(h2 + 35);

        // request held high across a busy burst
        h = cyc;
        en_q.push_back(4); en_q.push_back(4); en_q.push_back(4); en_q.push_back(4);
        bus.req_valid = 1'b1;
        bus.req_len   = 16'd1;
        tick();
        tick_to(h + 21);
        bus.in_valid = 1'b1;
        push_exp(0, 1, h + 21);
        push_exp(1, 0, h + 33);
        tick();
        bus.in_valid = 1'b0;
        tick_to(h + 33);
        check("held_req_ready_guard", bus.req_ready, 0);
        tick();
        check("held_req_ready_idle", bus.req_ready, 1);
        push_exp(0, 1, h + 55);
        push_exp(1, 0, h + 67);
        tick();
        bus.req_valid = 1'b0;
        check("held_second_busy", busy, 1);
        tick_to(h + 55);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick_to(h + 69);

        // maximum length burst
        h = cyc;
        en_q.push_back(4); en_q.push_back(4);
        handshake(65535);
        tick_to(h + 21);
        bus.in_valid = 1'b1;
        for (int i = 0; i < 65535; i++) begin
            push_exp(0, i == 65534, h + 21 + i);
            if (i == 65534) push_exp(1, 0, h + 21 + i + 12);
            tick();
        end
        bus.in_valid = 1'b0;
        tick_to(h + 21 + 65534 + 15);

        check("scoreboard_drained", exp_q.size(), 0);
        check("enable_queue_drained", en_q.size(), 0);
        check("final_idle_ready", bus.req_ready, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
